// File: rtl/cnt_pkg.sv
// Shared constants and elaboration-time parameter checks for the modulo counter family.
package cnt_pkg;

  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  // Number of bits needed to hold the value n-1; at least 1.
  function automatic int cnt_bits(input longint unsigned n);
    int b;
    longint unsigned v;
    b = 0;
    v = n - 64'd1;
    while (v > 0) begin
      b = b + 1;
      v = v >> 1;
    end
    return (b == 0) ? 1 : b;
  endfunction

  function automatic bit cnt_params_ok(input int width, input longint unsigned modulo,
                                       input longint unsigned reset_val);
    return (width >= 1) && (width <= 32) && (modulo >= 2) &&
           (cnt_bits(modulo) <= width) && (reset_val < modulo);
  endfunction

endpackage

// File: rtl/counter_updown_mod.sv
// Up/down modulo counter with clear/load, wrap or saturate, sticky overflow and cascade carry.
// count changes 1 cycle after the qualifying edge; carry_out is combinational; no backpressure.
module counter_updown_mod
  import cnt_pkg::*;
#(
  parameter int              WIDTH     = 4,
  parameter longint unsigned MODULO    = 16,
  parameter bit              SATURATE  = 1'b0,
  parameter longint unsigned RESET_VAL = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             carry_out,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam int               W1      = WIDTH + 1;
  localparam logic [W1-1:0]    MOD_EXT = W1'(MODULO);
  localparam logic [W1-1:0]    TOP_EXT = W1'(MODULO - 64'd1);
  localparam logic [WIDTH-1:0] TOP_CNT = WIDTH'(MODULO - 64'd1);
  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);

  if (!cnt_params_ok(WIDTH, MODULO, RESET_VAL)) begin : g_bad_params
    $error("counter_updown_mod: illegal WIDTH/MODULO/RESET_VAL combination");
  end

  logic [W1-1:0]    inc;
  logic [W1-1:0]    dec;
  logic             at_top;
  logic             at_bot;
  logic             boundary;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] count_nxt;
  logic             ovf_nxt;

  // One extra bit: the increment's carry marks MODULO==2**WIDTH roll-over, the decrement's borrow marks zero.
  always_comb begin
    inc          = {1'b0, count} + W1'(1);
    dec          = {1'b0, count} - W1'(1);
    at_top       = (inc == MOD_EXT);
    at_bot       = dec[WIDTH];
    load_clamped = ({1'b0, load_val} > TOP_EXT) ? TOP_CNT : load_val;
    boundary     = enable & ~clear & ~load & ((up == CNT_UP) ? at_top : at_bot);
    count_nxt    = count;
    if (clear) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = load_clamped;
    end else if (enable) begin
      if (boundary) begin
        count_nxt = SATURATE ? count : ((up == CNT_UP) ? '0 : TOP_CNT);
      end else begin
        count_nxt = (up == CNT_UP) ? inc[WIDTH-1:0] : dec[WIDTH-1:0];
      end
    end
    ovf_nxt = boundary | (overflow & ~ovf_clr);
  end

  assign carry_out = boundary;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count    <= RST_CNT;
      overflow <= 1'b0;
    end else begin
      count    <= count_nxt;
      overflow <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: three single instances on shared inputs plus a decimal cascade,
// compared each cycle against an arithmetic model, with literal expectations for the directed cases.
module tb_counter_updown_mod;

  logic       clock;
  logic       reset;
  logic       clear, load, enable, up, ovf_clr;
  logic [3:0] load_val;
  logic [3:0] cnt [3];
  logic       cy  [3];
  logic       ov  [3];
  logic       cas_en;
  logic [3:0] lo_cnt, hi_cnt;
  logic       lo_cy, hi_cy, lo_ov, hi_ov;

  int  tests = 0;
  int  fails = 0;
  bit  chk_on = 0;
  int  mods [3];
  bit  sats [3];
  int  mc   [3];
  bit  mo   [3];
  bit  mb   [3];
  int  cv;
  bit  clo_ov, chi_ov;
  int  pulses;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  counter_updown_mod #(.WIDTH(4), .MODULO(16), .SATURATE(1'b0), .RESET_VAL(0)) u_def (
    .clock(clock), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
    .enable(enable), .up(up), .count(cnt[0]), .carry_out(cy[0]), .overflow(ov[0]), .ovf_clr(ovf_clr));
  counter_updown_mod #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0), .RESET_VAL(0)) u_wrap (
    .clock(clock), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
    .enable(enable), .up(up), .count(cnt[1]), .carry_out(cy[1]), .overflow(ov[1]), .ovf_clr(ovf_clr));
  counter_updown_mod #(.WIDTH(4), .MODULO(10), .SATURATE(1'b1), .RESET_VAL(0)) u_sat (
    .clock(clock), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
    .enable(enable), .up(up), .count(cnt[2]), .carry_out(cy[2]), .overflow(ov[2]), .ovf_clr(ovf_clr));
  counter_updown_mod #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0), .RESET_VAL(0)) u_lo (
    .clock(clock), .reset(reset), .clear(1'b0), .load(1'b0), .load_val(4'd0),
    .enable(cas_en), .up(1'b1), .count(lo_cnt), .carry_out(lo_cy), .overflow(lo_ov), .ovf_clr(1'b0));
  counter_updown_mod #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0), .RESET_VAL(0)) u_hi (
    .clock(clock), .reset(reset), .clear(1'b0), .load(1'b0), .load_val(4'd0),
    .enable(lo_cy), .up(1'b1), .count(hi_cnt), .carry_out(hi_cy), .overflow(hi_ov), .ovf_clr(1'b0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_boundary(input int c, input int m, input bit en, input bit clr,
                                    input bit ld, input bit u);
    return en && !clr && !ld && (u ? (c == m - 1) : (c == 0));
  endfunction

  function automatic int m_next(input int c, input int m, input bit s, input bit clr, input bit ld,
                                input int lv, input bit en, input bit u);
    if (clr) return 0;
    if (ld) return (lv >= m) ? m - 1 : lv;
    if (!en) return c;
    if (u) return s ? ((c + 1 < m) ? c + 1 : c) : (c + 1) % m;
    return s ? ((c > 0) ? c - 1 : 0) : (c + m - 1) % m;
  endfunction

  // Reference model: single counters as modular arithmetic, the cascade as one decimal value 0..99.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        mc[i] = 0;
        mo[i] = 1'b0;
      end
      cv     = 0;
      clo_ov = 1'b0;
      chi_ov = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        mb[i] = m_boundary(mc[i], mods[i], enable, clear, load, up);
        mo[i] = mb[i] | (mo[i] & !ovf_clr);
        mc[i] = m_next(mc[i], mods[i], sats[i], clear, load, int'(load_val), enable, up);
      end
      if (cas_en) begin
        if (cv % 10 == 9) clo_ov = 1'b1;
        if (cv == 99) chi_ov = 1'b1;
        cv = (cv + 1) % 100;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("count[%0d]", i), 32'(cnt[i]), mc[i]);
        chk($sformatf("carry[%0d]", i), 32'(cy[i]),
            32'(m_boundary(mc[i], mods[i], enable, clear, load, up)));
        chk($sformatf("overflow[%0d]", i), 32'(ov[i]), 32'(mo[i]));
      end
      chk("cas_lo", 32'(lo_cnt), cv % 10);
      chk("cas_hi", 32'(hi_cnt), cv / 10);
      chk("cas_lo_carry", 32'(lo_cy), 32'(cas_en && (cv % 10 == 9)));
      chk("cas_hi_carry", 32'(hi_cy), 32'(cas_en && (cv == 99)));
      chk("cas_lo_ovf", 32'(lo_ov), 32'(clo_ov));
      chk("cas_hi_ovf", 32'(hi_ov), 32'(chi_ov));
    end
  end

  task automatic drive(input bit clr, input bit ld, input logic [3:0] lv, input bit en,
                       input bit u, input bit oc);
    clear    = clr;
    load     = ld;
    load_val = lv;
    enable   = en;
    up       = u;
    ovf_clr  = oc;
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic look();
    @(negedge clock);
  endtask

  int exp_up  [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
  int exp_sd  [4]  = '{2, 1, 0, 0};
  int exp_scy [4]  = '{0, 0, 1, 1};
  int exp_sov [4]  = '{0, 0, 0, 1};

  initial begin
    mods = '{16, 10, 10};
    sats = '{1'b0, 1'b0, 1'b1};
    reset = 1'b1;
    cas_en = 1'b0;
    drive(0, 0, 4'd0, 0, 1, 0);
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_count", 32'(cnt[i]), 0);
      chk("reset_ovf", 32'(ov[i]), 0);
    end
    chk_on = 1'b1;
    nxt();
    reset = 1'b1;

    // MODULO=10 wrapping up-count over 12 edges
    drive(0, 0, 4'd0, 1, 1, 0);
    for (int i = 0; i < 12; i++) begin
      look();
      chk("up_seq_count", 32'(cnt[1]), exp_up[i]);
      chk("up_seq_carry", 32'(cy[1]), 32'(exp_up[i] == 9));
      nxt();
    end
    drive(0, 0, 4'd0, 0, 1, 0);
    look();
    chk("up_seq_final", 32'(cnt[1]), 2);
    chk("up_seq_ovf", 32'(ov[1]), 1);
    chk("def_count_12", 32'(cnt[0]), 12);
    chk("def_no_ovf", 32'(ov[0]), 0);
    nxt();

    // Default instance: force a wrap, load 7, then async reset mid-cycle
    drive(0, 1, 4'd15, 0, 1, 0);
    nxt();
    drive(0, 0, 4'd0, 1, 1, 0);
    nxt();
    drive(0, 1, 4'd7, 0, 1, 0);
    nxt();
    drive(0, 0, 4'd0, 0, 1, 0);
    look();
    chk("def_loaded_7", 32'(cnt[0]), 7);
    chk("def_wrap_ovf", 32'(ov[0]), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_count", 32'(cnt[0]), 0);
    chk("async_rst_ovf", 32'(ov[0]), 0);
    chk("async_rst_wrap", 32'(cnt[1]), 0);
    nxt();
    reset = 1'b1;

    // Saturating down-count from 2
    drive(0, 1, 4'd2, 0, 0, 0);
    nxt();
    drive(0, 0, 4'd0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      look();
      chk("sat_dn_count", 32'(cnt[2]), exp_sd[i]);
      chk("sat_dn_carry", 32'(cy[2]), exp_scy[i]);
      chk("sat_dn_ovf", 32'(ov[2]), exp_sov[i]);
      nxt();
    end
    drive(0, 0, 4'd0, 0, 0, 0);
    look();
    chk("sat_dn_final", 32'(cnt[2]), 0);
    chk("sat_dn_ovf_final", 32'(ov[2]), 1);
    nxt();

    // Priority: clear beats load and enable; load clamps to MODULO-1
    drive(0, 1, 4'd3, 0, 1, 0);
    nxt();
    drive(1, 1, 4'd5, 1, 1, 0);
    look();
    chk("prio_carry", 32'(cy[1]), 0);
    nxt();
    drive(0, 1, 4'd15, 0, 1, 0);
    look();
    chk("prio_clear", 32'(cnt[1]), 0);
    nxt();
    drive(0, 0, 4'd0, 0, 1, 0);
    look();
    chk("load_clamp", 32'(cnt[1]), 9);

    // Overflow: ovf_clr alone clears, set wins over a simultaneous clear
    nxt();
    drive(0, 0, 4'd0, 0, 1, 1);
    nxt();
    drive(0, 0, 4'd0, 0, 1, 0);
    look();
    chk("ovf_clr_alone", 32'(ov[1]), 0);
    chk("ovf_clr_hold_cnt", 32'(cnt[1]), 9);
    nxt();
    drive(0, 0, 4'd0, 1, 1, 1);
    look();
    chk("ovf_set_carry", 32'(cy[1]), 1);
    nxt();
    drive(0, 0, 4'd0, 0, 1, 0);
    look();
    chk("ovf_set_wins", 32'(ov[1]), 1);
    chk("ovf_set_wrap", 32'(cnt[1]), 0);
    nxt();
    drive(0, 0, 4'd0, 0, 1, 1);
    nxt();
    drive(0, 0, 4'd0, 0, 1, 0);
    look();
    chk("ovf_clr_after", 32'(ov[1]), 0);

    // Two-digit decimal cascade 00..99 and back to 00
    #2 reset = 1'b0;
    nxt();
    reset = 1'b1;
    cas_en = 1'b1;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      look();
      chk("cascade_value", 32'(hi_cnt) * 10 + 32'(lo_cnt), i);
      if (hi_cy) pulses++;
      nxt();
    end
    cas_en = 1'b0;
    look();
    chk("cascade_wrap_hi", 32'(hi_cnt), 0);
    chk("cascade_wrap_lo", 32'(lo_cnt), 0);
    chk("cascade_hi_pulses", pulses, 1);
    chk("cascade_hi_ovf", 32'(hi_ov), 1);
    nxt();

    // Randomized traffic with occasional mid-cycle async reset
    for (int n = 0; n < 1500; n++) begin
      drive($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)),
            $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
      cas_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) begin
        #3 reset = 1'b0;
      end
      nxt();
      reset = 1'b1;
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
